mux_scan_tx: RTL and testbench
==============================

# mux_scan_tx

Channel scanner and serial transmitter that sits directly downstream of the 8-to-1 byte multiplexer. It drives the multiplexer's 3-bit select and captures the selected byte. It then shifts each byte out on a UART-style line: 1 start bit, 8 data bits LSB first, 1 stop bit. One start pulse sends one frame: every channel enabled in a mask, in ascending index order.

## Interface
- BAUD_CNT_MAX, default 5208: clock cycles per serial bit (5208 = 9600 baud at 50 MHz); legal range ≥ 2.
- sys_clk  input  1  system clock; all logic is rising-edge.
- sys_rst_n  input  1  synchronous, active-low reset, sampled on the sys_clk rising edge.
- start  input  1  frame request, sampled each cycle; acted on only when idle.
- ch_mask  input  8  channel enables; bit i enables mux input i (0 = A … 7 = H); sampled only with an accepted start.
- mux_data  input  8  selected byte returned from the multiplexer output.
- sel  output  3  registered select driven to the multiplexer.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse when a frame finishes.

## Operation
- States: IDLE, SELECT, SEND.
- IDLE, start=1, ch_mask≠0:
  - latch ch_mask into an internal pending mask.
  - go to SELECT with sel = lowest set bit; busy ← 1.
- IDLE, start=1, ch_mask=0: stay in IDLE, pulse frame_done next cycle; busy and tx unchanged.
- SELECT (exactly 1 cycle):
  - sel is stable and mux_data is treated as settled.
  - on exit, capture mux_data into the shift register, clear that channel's pending bit, and go to SEND.
- SEND: 10 bit periods of BAUD_CNT_MAX cycles each.
  - order: tx=0 (start bit), then data[0]..data[7], then tx=1 (stop bit).
  - a baud counter runs 0..BAUD_CNT_MAX−1; a bit counter runs 0..9.
- End of the stop bit:
  - pending mask ≠ 0: go to SELECT with sel = next lowest set bit.
  - pending mask = 0: go to IDLE with busy ← 0 and frame_done ← 1 for that one cycle.
- start while busy is ignored. ch_mask changes during a frame have no effect.
- sel holds its last value in IDLE.
- tx=1 in IDLE and in SELECT.
- mux_data is only sampled on the final edge of SELECT.
- Reset mid-frame:
  - on the next edge, go to IDLE: tx=1, sel=0, busy=0, frame_done=0, counters and pending mask cleared.
  - the partial byte is abandoned and no frame_done is issued.

## Timing
- Reset values: tx=1, sel=3'd0, busy=0, frame_done=0.
- Start accepted on edge k:
  - busy=1 and sel valid from cycle k+1 (SELECT).
  - tx falls at cycle k+2.
- Per channel: 1 + 10·BAUD_CNT_MAX cycles.
- n enabled channels: frame_done high in cycle k+1+n·(1+10·BAUD_CNT_MAX), with busy=0 in that same cycle. A new start is accepted in that cycle.
- Empty mask: frame_done high in cycle k+1.
- Mux path latency: the multiplexer is combinational, so mux_data must settle within the single SELECT cycle.

## Test plan
All scenarios use BAUD_CNT_MAX=4 and a behavioural 8:1 mux model.
- Reset: hold sys_rst_n=0 for 3 cycles -> tx=1, sel=0, busy=0, frame_done=0.
- Two channels:
  - stimulus: ch_mask=8'b0000_0101, A=8'h55, C=8'hA3, start pulse on edge k.
  - required: sel=0 at k+1; tx carries 0x55 (LSB first) from k+2 to k+42.
  - required: sel=2 at k+42; tx carries 0xA3 from k+43 to k+83.
  - required: frame_done and busy=0 at k+83.
- Full scan:
  - stimulus: ch_mask=8'hFF, inputs A..H = 8'h01..8'h08.
  - required: sel steps 0..7; decoded bytes 01..08 in order; frame_done at k+1+8·41 = k+329.
- Empty mask: ch_mask=0, start -> frame_done at k+1; busy stays 0; tx stays 1.
- Ignored inputs:
  - stimulus: start at k; then change ch_mask and pulse start again at k+10.
  - required: the second start is ignored, the original mask is honoured, and only one frame_done occurs.
- Reset mid-byte: sys_rst_n=0 during data bit 3 -> the next cycle shows tx=1, busy=0, sel=0, and no frame_done follows.

Source files
------------

// File: rtl/mux_scan_tx.sv
// -----------------------------------------------------------------------------
// mux_scan_tx
// Channel scanner and serial transmitter for an 8:1 byte multiplexer.
// A start request scans every channel enabled in ch_mask in ascending order.
// For each channel it drives sel, captures mux_data, and sends the byte as a
// UART frame: one start bit, 8 data bits LSB first, one stop bit.
//
// Ports
//   sys_clk     system clock, rising edge
//   sys_rst_n   synchronous active-low reset
//   start       frame request, only acted on while idle
//   ch_mask     channel enables, bit i = mux input i, sampled with start
//   mux_data    byte returned by the multiplexer for the current sel
//   sel         registered multiplexer select
//   tx          serial line, idle high
//   busy        high while a frame is in progress
//   frame_done  one-cycle pulse when a frame (or an empty request) completes
// -----------------------------------------------------------------------------
module mux_scan_tx #(
   parameter int unsigned BAUD_CNT_MAX = 5208
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       start,
   input  logic [7:0] ch_mask,
   input  logic [7:0] mux_data,
   output logic [2:0] sel,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned BAUD_W   = (BAUD_CNT_MAX > 2) ? $clog2(BAUD_CNT_MAX) : 1;
   localparam int unsigned BIT_W    = 4;
   localparam int unsigned BIT_STOP = 9;
   localparam int unsigned BIT_LAST_DATA = 8;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
   localparam logic [BIT_W-1:0]  BIT_STOP_V = BIT_W'(BIT_STOP);
   localparam logic [BIT_W-1:0]  BIT_DATA_V = BIT_W'(BIT_LAST_DATA);

   if (BAUD_CNT_MAX < 2) begin : g_bad_baud
      $error("mux_scan_tx: BAUD_CNT_MAX must be at least 2");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SELECT = 2'd1,
      S_SEND   = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [BAUD_W-1:0]   baud_cnt;
   logic [BAUD_W-1:0]   baud_cnt_nxt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [BIT_W-1:0]    bit_cnt_nxt;
   logic [7:0]          data;
   logic [7:0]          data_nxt;
   logic [7:0]          pending;
   logic [7:0]          pending_nxt;
   logic [2:0]          sel_nxt;
   logic                tx_nxt;
   logic                busy_nxt;
   logic                frame_done_nxt;

   logic                baud_end;
   logic                stop_end;

   // Index of the lowest set bit; callers guarantee a non-zero mask.
   function automatic logic [2:0] lowest_set(input logic [7:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // Last cycle of a bit period, and last cycle of the stop bit.
   assign baud_end = (state == S_SEND) && (baud_cnt == BAUD_LAST);
   assign stop_end = baud_end && (bit_cnt == BIT_STOP_V);

   // State and output registers.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state      <= S_IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         data       <= '0;
         pending    <= '0;
         sel        <= 3'd0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         baud_cnt   <= baud_cnt_nxt;
         bit_cnt    <= bit_cnt_nxt;
         data       <= data_nxt;
         pending    <= pending_nxt;
         sel        <= sel_nxt;
         tx         <= tx_nxt;
         busy       <= busy_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start && (ch_mask != 8'd0)) state_nxt = S_SELECT;
         end
         S_SELECT: begin
            state_nxt = S_SEND;
         end
         S_SEND: begin
            if (stop_end) state_nxt = (pending != 8'd0) ? S_SELECT : S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath and next values of the registered outputs.
   always_comb begin
      baud_cnt_nxt   = baud_cnt;
      bit_cnt_nxt    = bit_cnt;
      data_nxt       = data;
      pending_nxt    = pending;
      sel_nxt        = sel;
      tx_nxt         = tx;
      busy_nxt       = busy;
      frame_done_nxt = 1'b0;

      case (state)
         S_IDLE: begin
            tx_nxt = 1'b1;
            if (start) begin
               if (ch_mask != 8'd0) begin
                  pending_nxt = ch_mask;
                  sel_nxt     = lowest_set(ch_mask);
                  busy_nxt    = 1'b1;
               end else begin
                  // Empty request completes immediately without touching the line.
                  frame_done_nxt = 1'b1;
               end
            end
         end

         S_SELECT: begin
            // mux_data has had the whole cycle to settle on the current sel.
            data_nxt     = mux_data;
            pending_nxt  = pending & ~(8'd1 << sel);
            baud_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
            tx_nxt       = 1'b0;
         end

         S_SEND: begin
            if (baud_end) begin
               baud_cnt_nxt = '0;
               if (bit_cnt == BIT_STOP_V) begin
                  tx_nxt = 1'b1;
                  if (pending != 8'd0) begin
                     sel_nxt = lowest_set(pending);
                  end else begin
                     busy_nxt       = 1'b0;
                     frame_done_nxt = 1'b1;
                  end
               end else begin
                  // Bit period b is followed by data[b] for b = 0..7, then the stop bit.
                  bit_cnt_nxt = bit_cnt + BIT_W'(1);
                  tx_nxt      = (bit_cnt == BIT_DATA_V) ? 1'b1 : data[bit_cnt[2:0]];
               end
            end else begin
               baud_cnt_nxt = baud_cnt + BAUD_W'(1);
            end
         end

         default: begin
            tx_nxt = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_mux_scan_tx.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_tx
// Directed bench for mux_scan_tx with BAUD_CNT_MAX = 4 and a behavioural
// 8:1 multiplexer. Offsets below count falling edges after the edge that
// accepts start (offset 1 = SELECT cycle of the first channel).
// -----------------------------------------------------------------------------
module tb_mux_scan_tx;

   localparam int unsigned BAUD = 4;

   logic       sys_clk;
   logic       sys_rst_n;
   logic       start;
   logic [7:0] ch_mask;
   logic [7:0] mux_data;
   logic [2:0] sel;
   logic       tx;
   logic       busy;
   logic       frame_done;

   logic [7:0] mux_in [8];
   int         total;
   int         bad;
   int         pcnt;
   int         k0;

   mux_scan_tx #(.BAUD_CNT_MAX(BAUD)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .start      (start),
      .ch_mask    (ch_mask),
      .mux_data   (mux_data),
      .sel        (sel),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   // Combinational 8:1 multiplexer model.
   assign mux_data = mux_in[sel];

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) pcnt <= pcnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Present start with mask m for one edge; returns just after the accepting edge.
   task automatic do_start(input logic [7:0] m);
      @(negedge sys_clk);
      start   = 1'b1;
      ch_mask = m;
      @(posedge sys_clk);
      #1;
      start   = 1'b0;
      ch_mask = ~m;
      k0      = pcnt;
   endtask

   // Called at the SELECT-cycle falling edge s; returns at s+40 with the decoded byte.
   task automatic recv_byte(output logic [7:0] b);
      logic [9:0] bits;
      @(negedge sys_clk);
      chk("tx_fall", 32'(tx), 32'd0);
      for (int j = 0; j < 10; j++) begin
         if (j == 0) @(negedge sys_clk);
         else repeat (BAUD) @(negedge sys_clk);
         bits[j] = tx;
      end
      repeat (2) @(negedge sys_clk);
      chk("start_bit", 32'(bits[0]), 32'd0);
      chk("stop_bit", 32'(bits[9]), 32'd1);
      b = bits[8:1];
   endtask

   initial begin
      logic [7:0] b;
      int         dcnt;
      int         first;

      sys_clk   = 1'b0;
      sys_rst_n = 1'b0;
      start     = 1'b0;
      ch_mask   = 8'h00;
      total     = 0;
      bad       = 0;
      pcnt      = 0;
      for (int i = 0; i < 8; i++) mux_in[i] = 8'h00;

      // Reset
      repeat (3) @(negedge sys_clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      // Two channels: A=0x55, C=0xA3
      mux_in[0] = 8'h55;
      mux_in[2] = 8'hA3;
      do_start(8'b0000_0101);
      @(negedge sys_clk);
      chk("two_sel0", 32'(sel), 32'd0);
      chk("two_busy", 32'(busy), 32'd1);
      chk("two_tx_select", 32'(tx), 32'd1);
      recv_byte(b);
      chk("two_byte0", 32'(b), 32'h55);
      @(negedge sys_clk);
      chk("two_sel2", 32'(sel), 32'd2);
      chk("two_tx_select2", 32'(tx), 32'd1);
      chk("two_no_done", 32'(frame_done), 32'd0);
      recv_byte(b);
      chk("two_byte1", 32'(b), 32'hA3);
      chk("two_busy_late", 32'(busy), 32'd1);
      @(negedge sys_clk);
      chk("two_done", 32'(frame_done), 32'd1);
      chk("two_idle_busy", 32'(busy), 32'd0);
      chk("two_done_off", 32'(pcnt - k0 + 1), 32'd83);
      @(negedge sys_clk);
      chk("two_done_pulse", 32'(frame_done), 32'd0);

      // Full scan: A..H = 01..08
      for (int i = 0; i < 8; i++) mux_in[i] = 8'(i + 1);
      do_start(8'hFF);
      @(negedge sys_clk);
      for (int c = 0; c < 8; c++) begin
         chk("full_sel", 32'(sel), 32'(c));
         recv_byte(b);
         chk("full_byte", 32'(b), 32'(c + 1));
         @(negedge sys_clk);
      end
      chk("full_done", 32'(frame_done), 32'd1);
      chk("full_busy", 32'(busy), 32'd0);
      chk("full_done_off", 32'(pcnt - k0 + 1), 32'd329);

      // Empty mask: sel keeps its last value (7)
      do_start(8'h00);
      @(negedge sys_clk);
      chk("empty_done", 32'(frame_done), 32'd1);
      chk("empty_busy", 32'(busy), 32'd0);
      chk("empty_tx", 32'(tx), 32'd1);
      chk("empty_sel_hold", 32'(sel), 32'd7);
      @(negedge sys_clk);
      chk("empty_done_pulse", 32'(frame_done), 32'd0);
      chk("empty_busy2", 32'(busy), 32'd0);

      // Ignored start and ch_mask while busy
      mux_in[1] = 8'h3C;
      do_start(8'b0000_0010);
      dcnt  = 0;
      first = -1;
      for (int off = 1; off <= 120; off++) begin
         @(negedge sys_clk);
         if (off == 9) begin
            start   = 1'b1;
            ch_mask = 8'hFF;
         end
         if (off == 10) start = 1'b0;
         if (frame_done === 1'b1) begin
            dcnt++;
            if (first < 0) first = off;
         end
      end
      chk("ign_done_count", 32'(dcnt), 32'd1);
      chk("ign_done_off", 32'(first), 32'd42);
      chk("ign_sel", 32'(sel), 32'd1);
      chk("ign_busy", 32'(busy), 32'd0);

      // Reset during data bit 3 of channel C (0xA3, bit3 = 0)
      do_start(8'b0000_0100);
      repeat (19) @(negedge sys_clk);
      chk("mid_tx_bit3", 32'(tx), 32'd0);
      chk("mid_sel", 32'(sel), 32'd2);
      chk("mid_busy", 32'(busy), 32'd1);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_sel", 32'(sel), 32'd0);
      chk("mid_rst_done", 32'(frame_done), 32'd0);
      sys_rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge sys_clk);
         if (frame_done !== 1'b0) dcnt++;
      end
      chk("mid_no_done", 32'(dcnt), 32'd0);
      chk("mid_idle_tx", 32'(tx), 32'd1);
      chk("mid_idle_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
